// File: rtl/nios_out_pio.sv
// Avalon-MM output PIO: a data register with set/clear aliases, plus a
// self-timed pulse mask XORed onto out_port. Readback is registered (1-cycle latency).
module nios_out_pio #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
  parameter int               PULSE_CYCLES = 50000000,
  parameter int               CNT_W        = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0]       ADDR_DATA   = 3'd0;
  localparam logic [2:0]       ADDR_SET    = 3'd4;
  localparam logic [2:0]       ADDR_CLR    = 3'd5;
  localparam logic [2:0]       ADDR_PULSE  = 3'd6;
  localparam logic [2:0]       ADDR_STATUS = 3'd7;
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] MASK_ZERO   = {WIDTH{1'b0}};

  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] mask_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] data_nxt_s;
  logic [WIDTH-1:0] mask_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [31:0]      rd_s;
  logic [WIDTH-1:0] wdata_s;
  logic             wr_s;
  logic             busy_s;
  logic             unused_wdata_s;

  assign wr_s           = chipselect & ~write_n;
  assign wdata_s        = writedata[WIDTH-1:0];
  assign unused_wdata_s = ^writedata;
  assign busy_s         = (cnt_r != CNT_ZERO);
  assign out_port       = data_r ^ mask_r;

  // Next-state for the data register, pulse mask and pulse counter
  always_comb begin
    data_nxt_s = data_r;
    mask_nxt_s = mask_r;
    cnt_nxt_s  = cnt_r;
    if (wr_s) begin
      case (address)
        ADDR_DATA: data_nxt_s = wdata_s;
        ADDR_SET:  data_nxt_s = data_r | wdata_s;
        ADDR_CLR:  data_nxt_s = data_r & ~wdata_s;
        default:   data_nxt_s = data_r;
      endcase
    end else begin
      data_nxt_s = data_r;
    end
    // A PULSE write always wins over the running count, including its terminal edge
    if (wr_s && (address == ADDR_PULSE)) begin
      mask_nxt_s = wdata_s;
      if (wdata_s != MASK_ZERO) begin
        cnt_nxt_s = CNT_LOAD;
      end else begin
        cnt_nxt_s = CNT_ZERO;
      end
    end else if (busy_s) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
      if (cnt_r == CNT_ONE) begin
        mask_nxt_s = MASK_ZERO;
      end else begin
        mask_nxt_s = mask_r;
      end
    end else begin
      mask_nxt_s = mask_r;
      cnt_nxt_s  = cnt_r;
    end
  end

  // Read mux, zero-extended; sampled every edge regardless of chipselect
  always_comb begin
    rd_s = 32'd0;
    case (address)
      ADDR_DATA:   rd_s[WIDTH-1:0] = data_r;
      ADDR_PULSE:  rd_s[WIDTH-1:0] = mask_r;
      ADDR_STATUS: rd_s[0]         = busy_s;
      default:     rd_s            = 32'd0;
    endcase
  end

  // State and read-data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r   <= RESET_VALUE;
      mask_r   <= MASK_ZERO;
      cnt_r    <= CNT_ZERO;
      readdata <= 32'd0;
    end else begin
      data_r   <= data_nxt_s;
      mask_r   <= mask_nxt_s;
      cnt_r    <= cnt_nxt_s;
      readdata <= rd_s;
    end
  end

endmodule

// File: tb/tb_nios_out_pio.sv
// Self-checking bench for nios_out_pio: directed table, hand-written pulse
// corner sequences, then random traffic against an absolute-time pulse model.
module tb_nios_out_pio;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a pulse written on edge k is visible while edge index < k+P
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  int          m_expire;
  int          m_edge;
  logic [31:0] m_rd;

  typedef struct {
    logic [2:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl[14];

  nios_out_pio #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .PULSE_CYCLES(P), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic m_visible(input int e);
    return e < m_expire;
  endfunction

  task automatic model_reset();
    m_data = 8'hA5; m_mask = 8'h00; m_expire = 0; m_edge = 0; m_rd = 32'd0;
  endtask

  task automatic model_edge(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    logic [7:0] w;
    w = wd[7:0];
    case (a)
      3'd0:    m_rd = {24'd0, m_data};
      3'd6:    m_rd = m_visible(m_edge) ? {24'd0, m_mask} : 32'd0;
      3'd7:    m_rd = {31'd0, m_visible(m_edge)};
      default: m_rd = 32'd0;
    endcase
    m_edge++;
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = w;
        3'd4: m_data = m_data | w;
        3'd5: m_data = m_data & ~w;
        3'd6: begin
          m_mask = w;
          m_expire = (w != 8'h00) ? m_edge + P : 0;
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [7:0] m_out();
    return m_visible(m_edge) ? (m_data ^ m_mask) : m_data;
  endfunction

  // One bus cycle: drive, clock, update model, sample 1 time unit after the edge
  task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
    @(posedge clk);
    model_edge(a, cs, wn, wd);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    step(a, 1'b1, 1'b0, wd);
  endtask

  task automatic idle(input logic [2:0] a);
    step(a, 1'b0, 1'b1, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {24'd0, out_port}, 32'h0000_00A5);
    chk("reset_rd", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    tbl[0]  = '{3'd0, 1'b0, 1'b1, 32'h0,         8'hA5, 32'h0000_00A5};
    tbl[1]  = '{3'd0, 1'b1, 1'b0, 32'h1234_0F0F, 8'h0F, 32'h0000_00A5};
    tbl[2]  = '{3'd0, 1'b0, 1'b1, 32'h0,         8'h0F, 32'h0000_000F};
    tbl[3]  = '{3'd4, 1'b1, 1'b0, 32'hFFFF_FFF0, 8'hFF, 32'h0};
    tbl[4]  = '{3'd5, 1'b1, 1'b0, 32'h0000_0081, 8'h7E, 32'h0};
    tbl[5]  = '{3'd0, 1'b0, 1'b1, 32'h0,         8'h7E, 32'h0000_007E};
    tbl[6]  = '{3'd0, 1'b1, 1'b0, 32'hAB00_0000, 8'h00, 32'h0000_007E};
    tbl[7]  = '{3'd6, 1'b1, 1'b0, 32'h0000_0003, 8'h03, 32'h0};
    tbl[8]  = '{3'd7, 1'b0, 1'b1, 32'h0,         8'h03, 32'h1};
    tbl[9]  = '{3'd7, 1'b0, 1'b1, 32'h0,         8'h03, 32'h1};
    tbl[10] = '{3'd7, 1'b0, 1'b1, 32'h0,         8'h03, 32'h1};
    tbl[11] = '{3'd7, 1'b0, 1'b1, 32'h0,         8'h00, 32'h1};
    tbl[12] = '{3'd7, 1'b0, 1'b1, 32'h0,         8'h00, 32'h0};
    tbl[13] = '{3'd6, 1'b0, 1'b1, 32'h0,         8'h00, 32'h0};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd);
      chk($sformatf("tbl%0d_out", i), {24'd0, out_port}, {24'd0, tbl[i].exp_out});
      chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
    end

    // Restart on the terminal edge: 03 for 4 cycles, then 0C for 4, no gap
    wr(3'd6, 32'h03);
    chk("rs_a0", {24'd0, out_port}, 32'h03);
    for (int i = 1; i < 4; i++) begin
      idle(3'd7);
      chk($sformatf("rs_a%0d", i), {24'd0, out_port}, 32'h03);
    end
    wr(3'd6, 32'h0C);
    chk("rs_b0", {24'd0, out_port}, 32'h0C);
    for (int i = 1; i < 4; i++) begin
      idle(3'd6);
      chk($sformatf("rs_b%0d", i), {24'd0, out_port}, 32'h0C);
    end
    idle(3'd7);
    chk("rs_end", {24'd0, out_port}, 32'h00);

    // Cancel mid-pulse
    wr(3'd6, 32'h05);
    idle(3'd0);
    chk("cn_active", {24'd0, out_port}, 32'h05);
    wr(3'd6, 32'h00);
    chk("cn_out", {24'd0, out_port}, 32'h00);
    idle(3'd7);
    chk("cn_status", readdata, 32'd0);

    // Data writes while a pulse is active
    wr(3'd0, 32'h10);
    wr(3'd6, 32'h01);
    chk("dp_pulse", {24'd0, out_port}, 32'h11);
    wr(3'd0, 32'h20);
    chk("dp_data", {24'd0, out_port}, 32'h21);
    idle(3'd0);
    idle(3'd0);
    chk("dp_still", {24'd0, out_port}, 32'h21);
    idle(3'd0);
    chk("dp_expired", {24'd0, out_port}, 32'h20);

    // Asynchronous reset mid-pulse
    wr(3'd6, 32'hFF);
    chk("ar_pre", {24'd0, out_port}, 32'hDF);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out", {24'd0, out_port}, 32'hA5);
    chk("ar_rd", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // chipselect low blocks writes
    step(3'd0, 1'b0, 1'b0, 32'h00);
    step(3'd6, 1'b0, 1'b0, 32'hFF);
    chk("cs0_out", {24'd0, out_port}, 32'hA5);
    step(3'd7, 1'b0, 1'b0, 32'hFF);
    chk("cs0_status", readdata, 32'd0);
    idle(3'd0);
    chk("cs0_data", readdata, 32'h0000_00A5);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] a;
      logic       w;
      a = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 3) == 0);
      if (w && a == 3'd6 && $urandom_range(0, 3) == 0) wr(a, 32'd0);
      else step(a, 1'($urandom_range(0, 1)) | w, ~w, $urandom);
      chk($sformatf("rnd%0d_out", i), {24'd0, out_port}, {24'd0, m_out()});
      chk($sformatf("rnd%0d_rd", i), readdata, m_rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
